// File: rtl/acc_apb_master.sv
// Command/response to APB3 master bridge: one outstanding transfer, registered APB outputs.
// Optional ACCESS-phase timeout abort is built in when ACC_APB_TIMEOUT_EN is defined.
module acc_apb_master #(
    parameter int APB_ADDR_WIDTH = 13,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]               cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic                      timeout,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state;

`ifdef ACC_APB_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCW-1:0] WAIT_MAX  = WCW'(TIMEOUT_CYCLES);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);
    logic [WCW-1:0] wait_cnt;
`else
    assign timeout = 1'b0;
`endif

    // A pending response blocks new commands so responses never overlap.
    assign cmd_ready = (state == IDLE) && !rsp_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef ACC_APB_TIMEOUT_EN
            timeout   <= 1'b0;
            wait_cnt  <= '0;
`endif
        end else begin
`ifdef ACC_APB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            if (rsp_valid && rsp_ready)
                rsp_valid <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        PADDR  <= cmd_addr;
                        PWRITE <= cmd_write;
                        PWDATA <= cmd_wdata;
                        PSEL   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
`ifdef ACC_APB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= PWRITE ? 32'h0 : PRDATA;
                        rsp_err   <= PSLVERR;
                        state     <= IDLE;
                    end
`ifdef ACC_APB_TIMEOUT_EN
                    else begin
                        if (wait_cnt != WAIT_MAX)
                            wait_cnt <= wait_cnt + 1'b1;
                        // This edge ends the last permitted stalled ACCESS cycle.
                        if (wait_cnt == WAIT_LAST) begin
                            PSEL      <= 1'b0;
                            PENABLE   <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= 32'h0;
                            rsp_err   <= 1'b1;
                            timeout   <= 1'b1;
                            state     <= IDLE;
                        end
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_apb_master.sv
// Self-checking bench for acc_apb_master: vector table, corner sequences, random traffic vs. memory model.
module tb_acc_apb_master;
    localparam int AW = 13;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err, timeout;
    logic [31:0]   rsp_rdata;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA, PRDATA;
    logic          PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

    always #5 clk = ~clk;

    acc_apb_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .timeout(timeout),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [AW-1:0] a);
        return 32'hA5A50000 ^ {19'h0, a};
    endfunction

    function automatic logic is_err(input logic [AW-1:0] a);
        return a[3:0] == 4'hE;
    endfunction

    // APB slave: memory with per-transfer wait count (255 = never ready); noise outside the completing cycle.
    int            slv_waits = 0;
    int            cnt = 0;
    int            addr_viol = 0;
    logic [AW-1:0] saddr;
    logic [31:0]   slv_mem [int];

    always @(negedge clk) begin
        if (!PSEL || !PENABLE) begin
            if (PSEL) begin
                cnt   = slv_waits;
                saddr = PADDR;
            end
            PREADY  = 1'($urandom);
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom);
        end else begin
            if (PADDR !== saddr) addr_viol++;
            if (cnt == 0) begin
                PREADY  = 1'b1;
                PSLVERR = is_err(PADDR);
                if (PWRITE) begin
                    PRDATA = $urandom;
                    if (!is_err(PADDR)) slv_mem[int'(PADDR)] = PWDATA;
                end else begin
                    PRDATA = slv_mem.exists(int'(PADDR)) ? slv_mem[int'(PADDR)] : init_val(PADDR);
                end
            end else begin
                if (cnt != 255) cnt--;
                PREADY  = 1'b0;
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom);
            end
        end
    end

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [31:0] d);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("cmd_accept", 32'(cmd_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic collect(output logic [31:0] rd, output logic err, output int lat);
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
        rd  = rsp_rdata;
        err = rsp_err;
    endtask

    task automatic consume(input int delay);
        repeat (delay) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_clear", 32'(rsp_valid), 32'h0);
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        int            waits;
        logic [31:0]   exp_rdata;
        logic          exp_err;
    } vec_t;

    vec_t tbl [9];
    logic [31:0] ref_mem [int];

    initial begin
        logic [31:0] rd, held;
        logic        er;
        int          lat;

        tbl[0] = '{1'b1, 13'h1FFF, 32'h00000001, 0, 32'h0,        1'b0};
        tbl[1] = '{1'b0, 13'h1FFF, 32'h0,        0, 32'h00000001, 1'b0};
        tbl[2] = '{1'b1, 13'h0005, 32'hDEADBEEF, 2, 32'h0,        1'b0};
        tbl[3] = '{1'b0, 13'h0005, 32'h0,        3, 32'hDEADBEEF, 1'b0};
        tbl[4] = '{1'b1, 13'h000E, 32'h12345678, 1, 32'h0,        1'b1};
        tbl[5] = '{1'b0, 13'h000E, 32'h0,        0, 32'hA5A5000E, 1'b1};
        tbl[6] = '{1'b0, 13'h0100, 32'h0,        1, 32'hA5A50100, 1'b0};
        tbl[7] = '{1'b1, 13'h0000, 32'hFFFFFFFF, 0, 32'h0,        1'b0};
        tbl[8] = '{1'b0, 13'h0000, 32'h0,        0, 32'hFFFFFFFF, 1'b0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_psel",    32'(PSEL),      32'h0);
        chk("rst_penable", 32'(PENABLE),   32'h0);
        chk("rst_rsp_vld", 32'(rsp_valid), 32'h0);
        chk("rst_paddr",   32'(PADDR),     32'h0);
        chk("rst_timeout", 32'(timeout),   32'h0);
        rst = 1'b0;
        chk("rst_cmd_rdy", 32'(cmd_ready), 32'h1);

        // Write timing: PSEL at T+1, PENABLE at T+2, response at T+3.
        slv_waits = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 13'h1FFF; cmd_wdata = 32'h1;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        chk("t1_psel",    32'(PSEL),      32'h1);
        chk("t1_penable", 32'(PENABLE),   32'h0);
        chk("t1_paddr",   32'(PADDR),     32'h1FFF);
        chk("t1_pwrite",  32'(PWRITE),    32'h1);
        @(negedge clk);
        chk("t2_psel",    32'(PSEL),      32'h1);
        chk("t2_penable", 32'(PENABLE),   32'h1);
        @(negedge clk);
        chk("t3_rsp_vld", 32'(rsp_valid), 32'h1);
        chk("t3_psel",    32'(PSEL),      32'h0);
        chk("t3_err",     32'(rsp_err),   32'h0);
        chk("t3_rdata",   rsp_rdata,      32'h0);
        consume(0);

        for (int i = 0; i < 9; i++) begin
            slv_waits = tbl[i].waits;
            issue(tbl[i].wr, tbl[i].addr, tbl[i].wdata);
            collect(rd, er, lat);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(3 + tbl[i].waits));
            consume(int'($urandom_range(0, 2)));
        end

        // Slave error, then a stalled consumer blocks the next command.
        slv_waits = 0;
        issue(1'b0, 13'h000E, 32'h0);
        collect(rd, er, lat);
        chk("err_flag",  32'(er), 32'h1);
        chk("err_rdata", rd,      32'hA5A5000E);
        held = rsp_rdata;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 13'h0200;
        for (int k = 0; k < 5; k++) begin
            chk("stall_cmd_rdy", 32'(cmd_ready), 32'h0);
            chk("stall_psel",    32'(PSEL),      32'h0);
            chk("stall_rsp_vld", 32'(rsp_valid), 32'h1);
            chk("stall_rdata",   rsp_rdata,      held);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("release_rsp_vld", 32'(rsp_valid), 32'h0);
        chk("release_cmd_rdy", 32'(cmd_ready), 32'h1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("next_psel",  32'(PSEL),  32'h1);
        chk("next_paddr", 32'(PADDR), 32'h0200);
        collect(rd, er, lat);
        chk("next_rdata", rd, 32'hA5A50200);
        consume(0);

        // Reset during ACCESS drops the bus at once and leaves no response.
        slv_waits = 255;
        issue(1'b0, 13'h0400, 32'h0);
        @(negedge clk);
        chk("pre_rst_penable", 32'(PENABLE), 32'h1);
`ifndef ACC_APB_TIMEOUT_EN
        repeat (40) @(negedge clk);
        chk("hang_penable", 32'(PENABLE),   32'h1);
        chk("hang_rsp_vld", 32'(rsp_valid), 32'h0);
        chk("hang_timeout", 32'(timeout),   32'h0);
`endif
        rst = 1'b1;
        #1;
        chk("midrst_psel",    32'(PSEL),    32'h0);
        chk("midrst_penable", 32'(PENABLE), 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        slv_waits = 0;
        chk("midrst_cmd_rdy", 32'(cmd_ready), 32'h1);
        for (int k = 0; k < 3; k++) begin
            chk("midrst_rsp_vld", 32'(rsp_valid), 32'h0);
            @(negedge clk);
        end

`ifdef ACC_APB_TIMEOUT_EN
        slv_waits = 255;
        issue(1'b0, 13'h0300, 32'h0);
        collect(rd, er, lat);
        chk("to_lat",     32'(lat),     32'(2 + TO));
        chk("to_pulse",   32'(timeout), 32'h1);
        chk("to_err",     32'(er),      32'h1);
        chk("to_rdata",   rd,           32'h0);
        chk("to_psel",    32'(PSEL),    32'h0);
        @(negedge clk);
        chk("to_pulse_end", 32'(timeout), 32'h0);
        slv_waits = 0;
        consume(0);
`endif

        // Random traffic in a region the directed tests leave untouched.
        for (int i = 0; i < 150; i++) begin
            logic          wr;
            logic [AW-1:0] a;
            logic [31:0]   d, exp_rd;
            logic          exp_er;
            int            w;
            wr = 1'($urandom);
            a  = 13'h040 + AW'($urandom_range(0, 31));
            d  = $urandom;
            w  = int'($urandom_range(0, 3));
            exp_er = is_err(a);
            if (wr) begin
                exp_rd = 32'h0;
                if (!exp_er) ref_mem[int'(a)] = d;
            end else begin
                exp_rd = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
            end
            slv_waits = w;
            issue(wr, a, d);
            collect(rd, er, lat);
            chk("rnd_rdata", rd,          exp_rd);
            chk("rnd_err",   32'(er),     32'(exp_er));
            chk("rnd_lat",   32'(lat),    32'(3 + w));
            consume(int'($urandom_range(0, 2)));
        end

        chk("paddr_stable", 32'(addr_viol), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
